// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the data-memory responder
// Optional DMEM_MISALIGN_TRAP_EN uses is_misaligned to flag misaligned half/word accesses.
package mem_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } addr_ctrl_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_e;

  localparam int WORD_BYTES = 4;

  // Stores only know SB/SH; every other store code is a full word.
  function automatic logic is_misaligned(input logic we, input logic [2:0] ctrl,
                                         input logic [1:0] off);
    logic is_byte;
    logic is_half;
    is_byte = (ctrl == LB) || (!we && ctrl == LBU);
    is_half = (ctrl == LH) || (!we && ctrl == LHU);
    if (is_byte) return 1'b0;
    if (is_half) return off[0];
    return off != 2'b00;
  endfunction

endpackage

// File: rtl/lane_unit.sv
// rtl/lane_unit.sv - combinational byte/half/word lane extract and store merge
// Optional DMEM_MISALIGN_TRAP_EN: misaligned accesses raise misalign, zero load data and mask.
module lane_unit
  import mem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  ctrl,
  input  logic [1:0]  off,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word,
  output logic [3:0]  byte_mask,
  output logic        misalign
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] wdata_rep;
  logic [3:0]  mask_raw;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = is_misaligned(we, ctrl, off);
`else
  assign misalign = 1'b0;
`endif

  // Halves always come from the lane picked by off[1], which force-aligns odd offsets.
  assign sel_byte = old_word[{off, 3'b000} +: 8];
  assign sel_half = off[1] ? old_word[31:16] : old_word[15:0];

  always_comb begin
    load_data = old_word;
    case (ctrl)
      LB:      load_data = {{24{sel_byte[7]}}, sel_byte};
      LH:      load_data = {{16{sel_half[15]}}, sel_half};
      LBU:     load_data = {24'd0, sel_byte};
      LHU:     load_data = {16'd0, sel_half};
      default: load_data = old_word;
    endcase
    if (misalign) load_data = 32'd0;
  end

  always_comb begin
    mask_raw  = 4'b1111;
    wdata_rep = wdata;
    case (ctrl)
      LB: begin
        mask_raw  = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      LH: begin
        mask_raw  = off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        mask_raw  = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
    byte_mask   = (we && !misalign) ? mask_raw : 4'b0000;
    merged_word = old_word;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (byte_mask[i]) merged_word[8*i +: 8] = wdata_rep[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - valid/ready data-memory responder with programmable wait states
// Optional DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses return rsp_err and skip the write.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_ctrl,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  resp_state_e state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic                  lat_we;
  logic [IDX_W-1:0]      lat_idx;
  logic [1:0]            lat_off;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [2:0]            lat_ctrl;

  logic req_fire;
  logic rsp_fire;
  logic access;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [31:0] old_word;
  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic [3:0]  byte_mask;
  logic        misalign;

  // Upper address bits alias the array, so they are deliberately dropped.
  logic addr_unused;
  assign addr_unused = ^req_addr[ADDR_WIDTH-1:IDX_W+2];

  assign old_word = mem[lat_idx];

  lane_unit u_lane (
    .we          (lat_we),
    .ctrl        (lat_ctrl),
    .off         (lat_off),
    .old_word    (old_word),
    .wdata       (lat_wdata),
    .load_data   (load_data),
    .merged_word (merged_word),
    .byte_mask   (byte_mask),
    .misalign    (misalign)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_off   <= '0;
      lat_wdata <= '0;
      lat_ctrl  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_ready <= (state_nxt == IDLE);
      if (req_fire) begin
        lat_we    <= req_we;
        lat_idx   <= req_addr[IDX_W+1:2];
        lat_off   <= req_addr[1:0];
        lat_wdata <= req_wdata;
        lat_ctrl  <= req_ctrl;
      end
      if (access) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= lat_we ? '0 : load_data;
        rsp_err   <= misalign;
      end else if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // The WAIT exit coincides with the count reaching zero; the first RESP cycle is the access.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_fire) begin
          if (LATENCY == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          state_nxt = RESP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_fire) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    req_fire = req_valid && req_ready;
    access   = (state == RESP) && !rsp_valid;
    rsp_fire = rsp_valid && rsp_ready;
  end

  always_ff @(posedge clk) begin
    if (access && (|byte_mask)) mem[lat_idx] <= merged_word;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder (LATENCY 2 and 0)
// Expectations follow DMEM_MISALIGN_TRAP_EN when it is defined for the build.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [1:0]        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [1:0][31:0]  req_addr, req_wdata, rsp_rdata;
  logic [1:0][2:0]   req_ctrl;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mdl [64];

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  data_mem_responder #(.LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ctrl(req_ctrl[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  data_mem_responder #(.LATENCY(0)) dut_l0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ctrl(req_ctrl[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic [2:0] f, input logic [31:0] r, input logic e);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = d; v.ctrl = f; v.rdata = r; v.err = e;
    return v;
  endfunction

  // Reference: access size in bytes, alignment by arithmetic, masks via shifts.
  task automatic model(input logic we, input logic [2:0] f, input logic [1:0] o,
                       input logic [31:0] d, input int wi,
                       output logic [31:0] rd, output logic er);
    int size;
    int base;
    logic [63:0] mask;
    logic [63:0] v;
    if (f == 3'd0 || (!we && f == 3'd4)) size = 1;
    else if (f == 3'd1 || (!we && f == 3'd5)) size = 2;
    else size = 4;
    er = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    er = (int'(o) % size) != 0;
`endif
    base = int'(o) - (int'(o) % size);
    mask = ((64'd1 << (8*size)) - 64'd1) << (8*base);
    rd = 32'd0;
    if (!er) begin
      if (we) begin
        mdl[wi] = 32'((64'(mdl[wi]) & ~mask) | ((64'(d) << (8*base)) & mask));
      end else begin
        v = (64'(mdl[wi]) & mask) >> (8*base);
        if ((f == 3'd0 || f == 3'd1) && v[8*size-1]) v = v - (64'd1 << (8*size));
        rd = v[31:0];
      end
    end
  endtask

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic txn(input int s, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [2:0] ctrl,
                     output logic [31:0] rdata, output logic err);
    int guard;
    int lat;
    guard = 0;
    while (req_ready[s] !== 1'b1 && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    if (req_ready[s] !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL req_ready_wait dut%0d: got %b, required 1", s, req_ready[s]);
    end
    req_valid[s] = 1'b1; req_we[s] = we; req_addr[s] = addr;
    req_wdata[s] = wdata; req_ctrl[s] = ctrl;
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    lat = 0;
    while (rsp_valid[s] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check($sformatf("latency_dut%0d", s), 32'(lat), (s == 0) ? 32'd3 : 32'd1);
    rdata = rsp_rdata[s];
    err   = rsp_err[s];
    rsp_ready[s] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[s] = 1'b0;
    check($sformatf("rsp_valid_clear_dut%0d", s), {31'd0, rsp_valid[s]}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd, exp_rd, addr, d;
    logic        er, exp_er, we;
    logic [2:0]  f;
    logic [1:0]  off;
    int          widx, lat;

    rst = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_ctrl = '0;
    rsp_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset_req_ready_dut%0d", s), {31'd0, req_ready[s]}, 32'd0);
      check($sformatf("reset_rsp_valid_dut%0d", s), {31'd0, rsp_valid[s]}, 32'd0);
      check($sformatf("reset_rsp_rdata_dut%0d", s), rsp_rdata[s], 32'd0);
      check($sformatf("reset_rsp_err_dut%0d", s), {31'd0, rsp_err[s]}, 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("req_ready_after_reset", {31'd0, req_ready[0]}, 32'd1);

    tbl.push_back(mk(1'b1, 32'h10,   32'hDEADBEEF, 3'b010, 32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 32'h10,   32'h0,        3'b010, 32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(1'b1, 32'h20,   32'h80FF7F01, 3'b010, 32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 32'h23,   32'h0,        3'b000, 32'hFFFFFF80, 1'b0));
    tbl.push_back(mk(1'b0, 32'h23,   32'h0,        3'b100, 32'h00000080, 1'b0));
    tbl.push_back(mk(1'b0, 32'h22,   32'h0,        3'b001, 32'hFFFF80FF, 1'b0));
    tbl.push_back(mk(1'b0, 32'h20,   32'h0,        3'b101, 32'h00007F01, 1'b0));
    tbl.push_back(mk(1'b0, 32'h21,   32'h0,        3'b000, 32'h0000007F, 1'b0));
    tbl.push_back(mk(1'b1, 32'h20,   32'h11223344, 3'b010, 32'h0,        1'b0));
    tbl.push_back(mk(1'b1, 32'h21,   32'hFFFFFFAA, 3'b000, 32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 32'h20,   32'h0,        3'b010, 32'h1122AA44, 1'b0));
    tbl.push_back(mk(1'b1, 32'h22,   32'h1234BEEF, 3'b001, 32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 32'h20,   32'h0,        3'b010, 32'hBEEFAA44, 1'b0));
    tbl.push_back(mk(1'b0, 32'h1010, 32'h0,        3'b011, 32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(1'b1, 32'h1000, 32'h0BADF00D, 3'b100, 32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 32'h0,    32'h0,        3'b111, 32'h0BADF00D, 1'b0));
    tbl.push_back(mk(1'b0, 32'h0,    32'h0,        3'b110, 32'h0BADF00D, 1'b0));
    tbl.push_back(mk(1'b1, 32'h30,   32'h0C0FFEE0, 3'b010, 32'h0,        1'b0));
    tbl.push_back(mk(1'b1, 32'h34,   32'h01020304, 3'b010, 32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 32'h20,   32'h0,        3'b101, 32'h0000AA44, 1'b0));
`ifdef DMEM_MISALIGN_TRAP_EN
    tbl.push_back(mk(1'b0, 32'h31,   32'h0,        3'b010, 32'h0,        1'b1));
    tbl.push_back(mk(1'b1, 32'h37,   32'h0000A5A5, 3'b001, 32'h0,        1'b1));
    tbl.push_back(mk(1'b0, 32'h34,   32'h0,        3'b010, 32'h01020304, 1'b0));
    tbl.push_back(mk(1'b0, 32'h23,   32'h0,        3'b001, 32'h0,        1'b1));
`else
    tbl.push_back(mk(1'b0, 32'h31,   32'h0,        3'b010, 32'h0C0FFEE0, 1'b0));
    tbl.push_back(mk(1'b1, 32'h37,   32'h0000A5A5, 3'b001, 32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 32'h34,   32'h0,        3'b010, 32'hA5A50304, 1'b0));
    tbl.push_back(mk(1'b0, 32'h23,   32'h0,        3'b001, 32'hFFFFBEEF, 1'b0));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].ctrl, rd, er);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].rdata);
      check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, tbl[i].err});
    end

    // Backpressure: response held 5 cycles while a second request waits on req_valid.
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10;
    req_wdata[0] = 32'h0; req_ctrl[0] = 3'b010;
    @(posedge clk); #1;
    check("bp_first_accepted", {31'd0, req_ready[0]}, 32'd0);
    req_addr[0] = 32'h20;
    lat = 0;
    while (rsp_valid[0] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("bp_latency", 32'(lat), 32'd3);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold%0d_valid", k), {31'd0, rsp_valid[0]}, 32'd1);
      check($sformatf("bp_hold%0d_rdata", k), rsp_rdata[0], 32'hDEADBEEF);
      check($sformatf("bp_hold%0d_req_ready", k), {31'd0, req_ready[0]}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    check("bp_release_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("bp_release_req_ready", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clk); #1;
    check("bp_second_accepted", {31'd0, req_ready[0]}, 32'd0);
    req_valid[0] = 1'b0;
    lat = 0;
    while (rsp_valid[0] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("bp_second_latency", 32'(lat), 32'd3);
    check("bp_second_rdata", rsp_rdata[0], 32'hBEEFAA44);
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;

    // Reset during WAIT of a store: the store must be dropped.
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h30;
    req_wdata[0] = 32'h55; req_ctrl[0] = 3'b010;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    check("midreset_req_ready", {31'd0, req_ready[0]}, 32'd0);
    check("midreset_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("midreset_rsp_rdata", rsp_rdata[0], 32'd0);
    check("midreset_rsp_err", {31'd0, rsp_err[0]}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    txn(0, 1'b0, 32'h30, 32'h0, 3'b010, rd, er);
    check("midreset_store_dropped", rd, 32'h0C0FFEE0);

    // Randomized traffic over words 64..127 with random aliasing upper bits.
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      mdl[i] = d;
      txn(0, 1'b1, 32'h100 + 32'(i) * 4, d, 3'b010, rd, er);
    end
    for (int i = 0; i < 150; i++) begin
      widx = $urandom_range(0, 63);
      off  = 2'($urandom_range(0, 3));
      f    = 3'($urandom_range(0, 7));
      we   = 1'($urandom_range(0, 1));
      d    = $urandom;
      addr = ($urandom & 32'hFFFF_F000) | 32'h100 | (32'(widx) << 2) | 32'(off);
      model(we, f, off, d, widx, exp_rd, exp_er);
      txn(0, we, addr, d, f, rd, er);
      check($sformatf("rnd%0d_rdata we=%b f=%0d a=%h", i, we, f, addr), rd, exp_rd);
      check($sformatf("rnd%0d_err", i), {31'd0, er}, {31'd0, exp_er});
    end

    // Zero wait states plus aliasing on the LATENCY=0 instance.
    txn(1, 1'b1, 32'h40, 32'h12345678, 3'b010, rd, er);
    check("l0_store_rdata", rd, 32'h0);
    txn(1, 1'b0, 32'h1040, 32'h0, 3'b010, rd, er);
    check("l0_alias_load", rd, 32'h12345678);
    txn(1, 1'b0, 32'h43, 32'h0, 3'b100, rd, er);
    check("l0_lbu", rd, 32'h00000012);
    txn(1, 1'b0, 32'h42, 32'h0, 3'b001, rd, er);
    check("l0_lh", rd, 32'h00001234);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
